// File: rtl/riscv_pkg.sv
// Shared constants for the writeback stage: result-select codes and datapath defaults.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  // Writeback result select encodings
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_ILL = 2'b11;

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register storage: x1..x(NREG-1), one write port, two async read
// ports. x0 has no storage and always reads as zero.
module regfile_2r1w
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = riscv_pkg::XLEN,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = riscv_pkg::AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regsQ [1:NREG-1];

  // Synchronous clear of the whole array, otherwise a single write (x0 ignored)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++) begin
        regsQ[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regsQ[waddr] <= wdata;
    end
  end

  // Asynchronous reads with x0 returning zero
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0) rdata1 = regsQ[raddr1];
    if (raddr2 != '0) rdata2 = regsQ[raddr2];
  end

endmodule

// File: rtl/writeback_regfile.sv
// W-stage writeback: result select, register commit, decode reads with
// same-cycle write-through bypass, illegal-select flag and retired counter.
module writeback_regfile
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = riscv_pkg::XLEN,
  parameter int unsigned NREG  = 32,
  parameter int unsigned AW    = riscv_pkg::AW,
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             validW,
  input  logic             regwriteW,
  input  logic [1:0]       wbselW,
  input  logic [AW-1:0]    rdW,
  input  logic [XLEN-1:0]  ALUresW,
  input  logic [XLEN-1:0]  data_readW,
  input  logic [XLEN-1:0]  pc4W,
  input  logic [AW-1:0]    rs1D,
  input  logic [AW-1:0]    rs2D,
  output logic [XLEN-1:0]  rd1D,
  output logic [XLEN-1:0]  rd2D,
  output logic [XLEN-1:0]  resultW,
  output logic             wen_effW,
  output logic             err_wbselW,
  output logic [CNT_W-1:0] instret
);

  logic [XLEN-1:0]  arrRd1;
  logic [XLEN-1:0]  arrRd2;
  logic [CNT_W-1:0] instretQ;
  logic [CNT_W-1:0] instretD;

  // Result select and commit qualification; the illegal select yields zero
  always_comb begin
    case (wbselW)
      WB_ALU:  resultW = ALUresW;
      WB_MEM:  resultW = data_readW;
      WB_PC4:  resultW = pc4W;
      default: resultW = '0;
    endcase
    wen_effW   = rst_n & validW & regwriteW & (rdW != '0) & (wbselW != WB_ILL);
    err_wbselW = rst_n & validW & regwriteW & (wbselW == WB_ILL);
  end

  regfile_2r1w #(
    .XLEN (XLEN),
    .NREG (NREG),
    .AW   (AW)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wen_effW),
    .waddr  (rdW),
    .wdata  (resultW),
    .raddr1 (rs1D),
    .raddr2 (rs2D),
    .rdata1 (arrRd1),
    .rdata2 (arrRd2)
  );

  // Decode reads: zero in reset or for x0, bypass the committing write, else the array
  always_comb begin
    rd1D = arrRd1;
    rd2D = arrRd2;
    if (!rst_n || rs1D == '0) begin
      rd1D = '0;
    end else if (wen_effW && rdW == rs1D) begin
      rd1D = resultW;
    end
    if (!rst_n || rs2D == '0) begin
      rd2D = '0;
    end else if (wen_effW && rdW == rs2D) begin
      rd2D = resultW;
    end
  end

  // Every valid W instruction retires, whether or not it writes; wraps freely
  always_comb begin
    instretD = instretQ;
    if (validW) instretD = instretQ + CNT_W'(1);
  end

  // Retired-instruction counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instretQ <= '0;
    end else begin
      instretQ <= instretD;
    end
  end

  assign instret = instretQ;

endmodule

// File: tb/tb_writeback_regfile.sv
module tb_writeback_regfile;

  int checks = 0;
  int errors = 0;

  logic        clk = 1'b1;
  logic        rst_n;
  logic        validW, regwriteW;
  logic [1:0]  wbselW;
  logic [4:0]  rdW, rs1D, rs2D;
  logic [31:0] ALUresW, data_readW, pc4W;
  logic [31:0] rd1D, rd2D, resultW;
  logic        wen_effW, err_wbselW;
  logic [63:0] instret;
  logic [31:0] rd1S, rd2S, resS;
  logic        wenS, errS;
  logic [3:0]  instret4;

  always #5 clk = ~clk;

  writeback_regfile dut (
    .clk(clk), .rst_n(rst_n), .validW(validW), .regwriteW(regwriteW), .wbselW(wbselW),
    .rdW(rdW), .ALUresW(ALUresW), .data_readW(data_readW), .pc4W(pc4W), .rs1D(rs1D),
    .rs2D(rs2D), .rd1D(rd1D), .rd2D(rd2D), .resultW(resultW), .wen_effW(wen_effW),
    .err_wbselW(err_wbselW), .instret(instret)
  );

  // Narrow-counter copy sharing the same stimulus, used for the wrap check
  writeback_regfile #(.CNT_W(4)) dutSmall (
    .clk(clk), .rst_n(rst_n), .validW(validW), .regwriteW(regwriteW), .wbselW(wbselW),
    .rdW(rdW), .ALUresW(ALUresW), .data_readW(data_readW), .pc4W(pc4W), .rs1D(rs1D),
    .rs2D(rs2D), .rd1D(rd1S), .rd2D(rd2S), .resultW(resS), .wen_effW(wenS),
    .err_wbselW(errS), .instret(instret4)
  );

  task automatic fail(input string n, input logic [63:0] got, input logic [63:0] exp);
    errors++;
    $display("FAIL %s: got %0h, expected %0h (t=%0t)", n, got, exp, $time);
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] sel,
                       input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [31:0] pc,
                       input logic [4:0] r1, input logic [4:0] r2);
    validW = v; regwriteW = rw; wbselW = sel; rdW = rd;
    ALUresW = alu; data_readW = mem; pc4W = pc; rs1D = r1; rs2D = r2;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with a live write pending on the inputs
    rst_n = 1'b0;
    drive(1, 1, 2'b00, 5'd5, 32'hDEAD_BEEF, 0, 0, 5'd5, 5'd0);
    checks++; if (rd1D !== 32'h0) fail("rst_rd1", rd1D, 0);
    checks++; if (wen_effW !== 1'b0) fail("rst_wen", wen_effW, 0);
    checks++; if (resultW !== 32'hDEAD_BEEF) fail("rst_result_mux", resultW, 32'hDEAD_BEEF);
    step();
    checks++; if (err_wbselW !== 1'b0) fail("rst_err", err_wbselW, 0);
    step();
    rst_n = 1'b1;
    drive(0, 0, 2'b00, 0, 0, 0, 0, 5'd5, 5'd0);
    checks++; if (rd1D !== 32'h0) fail("post_rst_x5", rd1D, 0);
    checks++; if (instret !== 64'd0) fail("post_rst_instret", instret, 0);
    step();

    // Three result sources
    drive(1, 1, 2'b00, 5'd1, 32'h4, 0, 0, 0, 0);
    checks++; if (resultW !== 32'h4) fail("alu_result", resultW, 32'h4);
    checks++; if (wen_effW !== 1'b1) fail("alu_wen", wen_effW, 1);
    step();
    drive(1, 1, 2'b01, 5'd3, 0, 32'hA5A5_A5A5, 0, 0, 0);
    checks++; if (resultW !== 32'hA5A5_A5A5) fail("mem_result", resultW, 32'hA5A5_A5A5);
    checks++; if (instret !== 64'd1) fail("instret_1", instret, 1);
    step();
    drive(1, 1, 2'b10, 5'd4, 0, 0, 32'h10, 0, 0);
    checks++; if (resultW !== 32'h10) fail("pc4_result", resultW, 32'h10);
    step();
    drive(0, 0, 2'b00, 0, 0, 0, 0, 5'd1, 5'd3);
    checks++; if (rd1D !== 32'h4) fail("x1", rd1D, 32'h4);
    checks++; if (rd2D !== 32'hA5A5_A5A5) fail("x3", rd2D, 32'hA5A5_A5A5);
    checks++; if (instret !== 64'd3) fail("instret_3", instret, 3);
    step();
    drive(0, 0, 2'b00, 0, 0, 0, 0, 5'd4, 5'd0);
    checks++; if (rd1D !== 32'h10) fail("x4", rd1D, 32'h10);
    checks++; if (rd2D !== 32'h0) fail("x0_port2", rd2D, 0);
    step();

    // Same-cycle bypass on both ports
    drive(1, 1, 2'b01, 5'd2, 0, 32'h1234_5678, 0, 5'd2, 5'd2);
    checks++; if (rd1D !== 32'h1234_5678) fail("bypass_rd1", rd1D, 32'h1234_5678);
    checks++; if (rd2D !== 32'h1234_5678) fail("bypass_rd2", rd2D, 32'h1234_5678);
    checks++; if (instret !== 64'd3) fail("instret_pre_bypass", instret, 3);
    step();
    drive(0, 0, 2'b00, 0, 0, 0, 0, 5'd2, 5'd1);
    checks++; if (rd1D !== 32'h1234_5678) fail("x2_array", rd1D, 32'h1234_5678);
    checks++; if (rd2D !== 32'h4) fail("x1_kept", rd2D, 32'h4);
    checks++; if (instret !== 64'd4) fail("instret_4", instret, 4);
    step();

    // x0 protection
    drive(1, 1, 2'b00, 5'd0, 32'hFFFF_FFFF, 0, 0, 5'd0, 5'd0);
    checks++; if (wen_effW !== 1'b0) fail("x0_wen", wen_effW, 0);
    checks++; if (rd1D !== 32'h0) fail("x0_read", rd1D, 0);
    step();
    drive(0, 0, 2'b00, 0, 0, 0, 0, 5'd0, 5'd0);
    checks++; if (rd1D !== 32'h0) fail("x0_after", rd1D, 0);
    checks++; if (instret !== 64'd5) fail("instret_x0", instret, 5);
    step();

    // Bubble with write intent
    drive(0, 1, 2'b00, 5'd6, 32'h77, 0, 0, 5'd6, 5'd0);
    checks++; if (wen_effW !== 1'b0) fail("bubble_wen", wen_effW, 0);
    checks++; if (err_wbselW !== 1'b0) fail("bubble_err", err_wbselW, 0);
    step();
    drive(0, 0, 2'b00, 0, 0, 0, 0, 5'd6, 5'd0);
    checks++; if (rd1D !== 32'h0) fail("bubble_x6", rd1D, 0);
    checks++; if (instret !== 64'd5) fail("bubble_instret", instret, 5);
    step();

    // Illegal writeback select
    drive(1, 1, 2'b11, 5'd6, 32'h77, 32'h88, 32'h99, 5'd6, 5'd0);
    checks++; if (err_wbselW !== 1'b1) fail("ill_err", err_wbselW, 1);
    checks++; if (resultW !== 32'h0) fail("ill_result", resultW, 0);
    checks++; if (wen_effW !== 1'b0) fail("ill_wen", wen_effW, 0);
    checks++; if (rd1D !== 32'h0) fail("ill_no_bypass", rd1D, 0);
    step();
    drive(0, 0, 2'b00, 0, 0, 0, 0, 5'd6, 5'd0);
    checks++; if (rd1D !== 32'h0) fail("ill_x6", rd1D, 0);
    checks++; if (instret !== 64'd6) fail("ill_instret", instret, 6);
    checks++; if (err_wbselW !== 1'b0) fail("ill_err_clear", err_wbselW, 0);
    step();

    // Reset mid-stream discards the in-flight write and clears state
    rst_n = 1'b0;
    drive(1, 1, 2'b00, 5'd7, 32'h55, 0, 0, 5'd1, 5'd7);
    checks++; if (rd1D !== 32'h0) fail("midrst_rd1", rd1D, 0);
    checks++; if (wen_effW !== 1'b0) fail("midrst_wen", wen_effW, 0);
    step();
    rst_n = 1'b1;
    drive(0, 0, 2'b00, 0, 0, 0, 0, 5'd7, 5'd1);
    checks++; if (rd1D !== 32'h0) fail("midrst_x7", rd1D, 0);
    checks++; if (rd2D !== 32'h0) fail("midrst_x1", rd2D, 0);
    checks++; if (instret !== 64'd0) fail("midrst_instret", instret, 0);
    step();

    // Counter wrap on the 4-bit build: 15 retires, then one more
    for (int i = 0; i < 15; i++) begin
      drive(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
      step();
    end
    drive(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    checks++; if (instret4 !== 4'd15) fail("wrap_pre", instret4, 15);
    checks++; if (instret !== 64'd15) fail("wide_pre", instret, 15);
    step();
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    checks++; if (instret4 !== 4'd0) fail("wrap_zero", instret4, 0);
    checks++; if (instret !== 64'd16) fail("wide_no_wrap", instret, 16);
    step();

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
